// File: rtl/ondra_snd_pkg.sv
// Shared definitions for the Ondra SPO 186 programmable tone generator.
//   - Per-channel register offsets and control-register bit positions.
//   - Legacy tone table used when ONDRA_LEGACY_SND_EN is defined.
//   - Channel-state record held by each ondra_tone_channel instance.
// Period and counter fields are stored zero-extended to DivWMax bits.
// Channels only ever operate on the low DIV_W bits, so DIV_W must not exceed DivWMax.
package ondra_snd_pkg;

  localparam logic [1:0] OffPerLo = 2'd0;
  localparam logic [1:0] OffPerHi = 2'd1;
  localparam logic [1:0] OffCtrl  = 2'd2;
  localparam logic [1:0] OffStat  = 2'd3;

  localparam int unsigned CtrlEn   = 0;
  localparam int unsigned CtrlMode = 1;

  localparam int unsigned DivWMax = 32;

  typedef enum logic {
    ModeSquare  = 1'b0,
    ModeOneShot = 1'b1
  } tone_mode_e;

  typedef struct packed {
    logic               en;
    tone_mode_e         mode;
    logic [3:0]         vol;
    logic [DivWMax-1:0] pending;
    logic [DivWMax-1:0] active;
    logic [DivWMax-1:0] cnt;
    logic               tone;
    logic               busy;
  } chan_state_t;

  // Half-periods in 1 MHz ticks reproducing the original seven fixed tones.
  function automatic logic [15:0] legacy_period(input logic [2:0] code);
    logic [15:0] per;
    case (code)
      3'd1:    per = 16'd1302;
      3'd2:    per = 16'd825;
      3'd3:    per = 16'd605;
      3'd4:    per = 16'd366;
      3'd5:    per = 16'd331;
      3'd6:    per = 16'd310;
      3'd7:    per = 16'd285;
      default: per = 16'd0;
    endcase
    return per;
  endfunction

endpackage

// File: rtl/ondra_tone_channel.sv
// One tone channel: period registers, control, and the half-period counter engine.
// Ports:
//   clk_sys, reset_n  clock and asynchronous active-low reset
//   tick              prescaler strobe; the counter advances only on tick
//   we, off, din      register write (we already qualified by channel select)
//   ovr, ovr_period   legacy override: forces EN=1, square mode, VOL=15 and the given period
//   restart           behaves like an EN 0->1 write, using the effective configuration
//   rd_off, rd_data   combinational register read view
//   tone, vol         current square level and effective volume, for the mixer
module ondra_tone_channel
  import ondra_snd_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        we,
  input  logic [1:0]  off,
  input  logic [7:0]  din,
  input  logic        ovr,
  input  logic [15:0] ovr_period,
  input  logic        restart,
  input  logic [1:0]  rd_off,
  output logic [7:0]  rd_data,
  output logic        tone,
  output logic [3:0]  vol
);

  chan_state_t      st_q, st_d;
  logic [7:0]       lo_q, lo_d;
  logic             eff_en;
  tone_mode_e       eff_mode;
  logic [DIV_W-1:0] eff_pend;
  logic [DIV_W-1:0] cnt_w;
  logic [15:0]      act16;

  always_comb begin
    eff_en   = ovr | st_q.en;
    eff_mode = ovr ? ModeSquare : st_q.mode;
    eff_pend = ovr ? DIV_W'(ovr_period) : DIV_W'(st_q.pending);
    cnt_w    = DIV_W'(st_q.cnt);
    st_d     = st_q;
    lo_d     = lo_q;

    if (eff_en && tick) begin
      if (cnt_w == '0) begin
        // The new period is adopted at the reload, so changes never truncate a half-period.
        st_d.active = DivWMax'(eff_pend);
        if (eff_pend == '0) begin
          st_d.tone = 1'b0;
        end else begin
          st_d.cnt = DivWMax'(eff_pend - DIV_W'(1));
          if (eff_mode == ModeSquare) begin
            st_d.tone = ~st_q.tone;
          end else if (!st_q.tone) begin
            st_d.tone = 1'b1;
          end else begin
            st_d.tone = 1'b0;
            st_d.en   = 1'b0;
          end
        end
      end else begin
        st_d.cnt = DivWMax'(cnt_w - DIV_W'(1));
      end
    end

    if (restart) begin
      st_d.active = DivWMax'(eff_pend);
      st_d.cnt    = '0;
      st_d.tone   = 1'b0;
    end

    // Applied after the tick logic so a control write beats a one-shot self-clear.
    if (we) begin
      case (off)
        OffPerLo: lo_d = din;
        OffPerHi: st_d.pending = DivWMax'(DIV_W'({din, lo_q}));
        OffCtrl: begin
          if (din[CtrlEn] && !st_q.en && !ovr) begin
            st_d.active = DivWMax'(DIV_W'(st_q.pending));
            st_d.cnt    = '0;
            st_d.tone   = 1'b0;
          end
          st_d.en   = din[CtrlEn];
          st_d.mode = tone_mode_e'(din[CtrlMode]);
          st_d.vol  = din[7:4];
        end
        default: ;
      endcase
    end

    if (!(ovr | st_d.en)) begin
      st_d.tone = 1'b0;
    end
    st_d.busy = st_d.en & (st_d.mode == ModeOneShot);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= '0;
      lo_q <= '0;
    end else begin
      st_q <= st_d;
      lo_q <= lo_d;
    end
  end

  assign act16 = st_q.active[15:0];

  always_comb begin
    case (rd_off)
      OffPerLo: rd_data = act16[7:0];
      OffPerHi: rd_data = act16[15:8];
      OffCtrl:  rd_data = {st_q.vol, 2'b00, logic'(st_q.mode), st_q.en};
      default:  rd_data = {6'b0, st_q.busy, st_q.tone};
    endcase
  end

  assign tone = st_q.tone;
  assign vol  = ovr ? 4'hF : st_q.vol;

endmodule

// File: rtl/ondra_tone_gen.sv
// Programmable multi-channel tone generator for the Ondra SPO 186 core.
// Holds the tick prescaler, register address decode, read-back mux, mixer and legacy override.
// Optional feature macro: ONDRA_LEGACY_SND_EN adds the 3-bit snd port driving channel 0.
// Ports:
//   clk_sys, reset_n  8 MHz system clock, asynchronous active-low reset
//   wr, rd            single-cycle write / read strobes
//   addr              {channel, offset}; din write data
//   dout              read data, registered, valid the cycle after rd
//   tone              raw per-channel square levels
//   audio             registered sum of the volumes of channels whose tone is high
//   snd               legacy tone select (ONDRA_LEGACY_SND_EN only)
module ondra_tone_gen
  import ondra_snd_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned PRESCALE = 8,
  parameter int unsigned AW       = $clog2(CHANNELS) + 2
) (
  input  logic                             clk_sys,
  input  logic                             reset_n,
  input  logic                             wr,
  input  logic                             rd,
  input  logic [AW-1:0]                    addr,
  input  logic [7:0]                       din,
`ifdef ONDRA_LEGACY_SND_EN
  input  logic [2:0]                       snd,
`endif
  output logic [7:0]                       dout,
  output logic [CHANNELS-1:0]              tone,
  output logic [3+$clog2(CHANNELS+1):0]    audio
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned ChW  = (AW > 2) ? AW - 2 : 1;
  localparam int unsigned AudW = 4 + $clog2(CHANNELS + 1);

  logic [PreW-1:0] pre_q;
  logic            tick;
  logic [ChW-1:0]  ch;
  logic [1:0]      off;
  logic [7:0]      rdata [CHANNELS];
  logic [3:0]      vol_w [CHANNELS];
  logic [CHANNELS-1:0] we;
  logic [7:0]      dout_d;
  logic [AudW-1:0] sum;
  logic            ovr;
  logic [15:0]     ovr_period;
  logic            restart;

  assign tick = (pre_q == PreW'(PRESCALE - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PreW'(1);
    end
  end

  // Shift rather than slice so a single-channel build (AW == 2) still elaborates.
  assign ch  = ChW'(addr >> 2);
  assign off = addr[1:0];

`ifdef ONDRA_LEGACY_SND_EN
  logic [2:0] snd_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      snd_q <= '0;
    end else begin
      snd_q <= snd;
    end
  end

  assign ovr        = (snd != 3'd0);
  assign ovr_period = legacy_period(snd);
  assign restart    = (snd != snd_q);
`else
  assign ovr        = 1'b0;
  assign ovr_period = '0;
  assign restart    = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign we[i] = wr && (ch == ChW'(i));

    ondra_tone_channel #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .tick       (tick),
      .we         (we[i]),
      .off        (off),
      .din        (din),
      .ovr        ((i == 0) ? ovr : 1'b0),
      .ovr_period (ovr_period),
      .restart    ((i == 0) ? restart : 1'b0),
      .rd_off     (off),
      .rd_data    (rdata[i]),
      .tone       (tone[i]),
      .vol        (vol_w[i])
    );
  end

  always_comb begin
    dout_d = 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch == ChW'(i)) begin
        dout_d = rdata[i];
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (tone[i]) begin
        sum = sum + AudW'(vol_w[i]);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dout  <= '0;
      audio <= '0;
    end else begin
      audio <= sum;
      if (rd) begin
        dout <= dout_d;
      end
    end
  end

endmodule

// File: tb/tb_ondra_tone_gen.sv
// Directed self-checking bench for ondra_tone_gen (3 channels, prescale 8).
module tb_ondra_tone_gen;

  localparam int AW = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic [2:0]    tone;
  logic [5:0]    audio;
`ifdef ONDRA_LEGACY_SND_EN
  logic [2:0]    snd;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ondra_tone_gen #(
    .CHANNELS (3),
    .DIV_W    (16),
    .PRESCALE (8),
    .AW       (AW)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .din     (din),
`ifdef ONDRA_LEGACY_SND_EN
    .snd     (snd),
`endif
    .dout    (dout),
    .tone    (tone),
    .audio   (audio)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input int c, input int o, input logic [7:0] d);
    @(negedge clk_sys);
    wr   = 1'b1;
    addr = AW'(c * 4 + o);
    din  = d;
    @(negedge clk_sys);
    wr   = 1'b0;
  endtask

  task automatic rd_reg(input int c, input int o, output logic [7:0] d);
    @(negedge clk_sys);
    rd   = 1'b1;
    addr = AW'(c * 4 + o);
    @(negedge clk_sys);
    rd   = 1'b0;
    d    = dout;
  endtask

  // Waits (bounded) for tone[c] to reach lvl; returns the cycle count at detection.
  task automatic wait_tone(input int c, input logic lvl, input int max_cyc, input string tag,
                           output int at);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < max_cyc && !hit; k++) begin
      @(negedge clk_sys);
      if (tone[c] == lvl) hit = 1'b1;
    end
    at = cyc;
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    logic [7:0] d;
    int t0, t1, t2;
    logic seen;

    reset_n = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    addr    = '0;
    din     = '0;
`ifdef ONDRA_LEGACY_SND_EN
    snd     = 3'd0;
`endif
    repeat (3) @(negedge clk_sys);
    check("rst_audio", 32'(audio), 32'd0);
    check("rst_tone", 32'(tone), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rd_reg(c, 3, d);
      check($sformatf("rst_status%0d", c), 32'(d), 32'h00);
    end

    // Channel 1: period 4, square, VOL 3 -> 32-cycle half-periods.
    wr_reg(1, 0, 8'h04);
    wr_reg(1, 1, 8'h00);
    wr_reg(1, 2, 8'h31);
    wait_tone(1, 1'b1, 100, "sq_rise", t0);
    check("audio_lag0", 32'(audio), 32'd0);
    @(negedge clk_sys);
    check("audio_lag1", 32'(audio), 32'd3);
    wait_tone(1, 1'b0, 100, "sq_fall", t1);
    check("sq_high_len", 32'(t1 - t0), 32'd32);
    wait_tone(1, 1'b1, 100, "sq_rise2", t2);
    check("sq_low_len", 32'(t2 - t1), 32'd32);
    rd_reg(1, 0, d);
    check("per_lo_read", 32'(d), 32'h04);

    // Period 4 -> 8 mid-tone: current half stays 32 cycles, next is 64.
    wait_tone(1, 1'b0, 100, "chg_sync_fall", t0);
    wait_tone(1, 1'b1, 100, "chg_sync_rise", t0);
    wr_reg(1, 0, 8'h08);
    wr_reg(1, 1, 8'h00);
    wait_tone(1, 1'b0, 100, "chg_fall", t1);
    check("chg_cur_half", 32'(t1 - t0), 32'd32);
    wait_tone(1, 1'b1, 200, "chg_rise", t2);
    check("chg_next_half", 32'(t2 - t1), 32'd64);
    wr_reg(1, 2, 8'h00);
    check("disable_tone", 32'(tone[1]), 32'd0);

    // Channel 0: period 10, one-shot, VOL 15 -> one 80-cycle pulse.
    wr_reg(0, 0, 8'd10);
    wr_reg(0, 1, 8'h00);
    wr_reg(0, 2, 8'hF3);
    wait_tone(0, 1'b1, 100, "os_rise", t0);
    @(negedge clk_sys);
    check("os_audio", 32'(audio), 32'd15);
    rd_reg(0, 3, d);
    check("os_status_busy", 32'(d), 32'h03);
    wait_tone(0, 1'b0, 200, "os_fall", t1);
    check("os_high_len", 32'(t1 - t0), 32'd80);
    @(negedge clk_sys);
    check("os_audio_end", 32'(audio), 32'd0);
    rd_reg(0, 2, d);
    check("os_ctrl_en_clr", 32'(d), 32'hF2);
    rd_reg(0, 3, d);
    check("os_status_end", 32'(d), 32'h00);

    // Same-cycle write and read: dout returns the pre-write value.
    @(negedge clk_sys);
    wr   = 1'b1;
    rd   = 1'b1;
    addr = AW'(2 * 4 + 2);
    din  = 8'h50;
    @(negedge clk_sys);
    wr   = 1'b0;
    rd   = 1'b0;
    check("wr_rd_old", 32'(dout), 32'h00);
    rd_reg(2, 2, d);
    check("wr_rd_new", 32'(d), 32'h50);

    // Period 1: toggle every tick (8 cycles).
    wr_reg(2, 0, 8'h01);
    wr_reg(2, 1, 8'h00);
    wr_reg(2, 2, 8'h11);
    wait_tone(2, 1'b1, 50, "p1_rise", t0);
    wait_tone(2, 1'b0, 50, "p1_fall", t1);
    check("p1_half", 32'(t1 - t0), 32'd8);
    wr_reg(2, 2, 8'h00);

    // Period 0: enabled but silent.
    wr_reg(2, 0, 8'h00);
    wr_reg(2, 1, 8'h00);
    wr_reg(2, 2, 8'h11);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk_sys);
      if (tone[2]) seen = 1'b1;
    end
    check("p0_silent", 32'(seen), 32'd0);
    wr_reg(2, 2, 8'h00);

    // All three at VOL 15 with equal periods -> overlapping highs sum to 45.
    for (int c = 0; c < 3; c++) begin
      wr_reg(c, 0, 8'd16);
      wr_reg(c, 1, 8'h00);
    end
    for (int c = 0; c < 3; c++) wr_reg(c, 2, 8'hF1);
    for (int k = 0; k < 400 && audio != 6'd45; k++) @(negedge clk_sys);
    check("mix_max", 32'(audio), 32'd45);
    check("mix_tones", 32'(tone), 32'h7);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_audio", 32'(audio), 32'd0);
    check("async_rst_tone", 32'(tone), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    rd_reg(0, 2, d);
    check("post_rst_ctrl", 32'(d), 32'h00);

`ifdef ONDRA_LEGACY_SND_EN
    // Legacy code 1: half-period 1302 ticks = 10416 cycles.
    @(negedge clk_sys);
    snd = 3'd1;
    wait_tone(0, 1'b1, 12000, "leg_rise", t0);
    wait_tone(0, 1'b0, 12000, "leg_fall", t1);
    check("leg_half", 32'(t1 - t0), 32'd10416);
    snd = 3'd0;
    seen = 1'b0;
    @(negedge clk_sys);
    repeat (50) begin
      @(negedge clk_sys);
      if (tone[0]) seen = 1'b1;
    end
    check("leg_off_silent", 32'(seen), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ondra_tone_gen.md
# ondra_tone_gen

Parametrised programmable tone generator for the Ondra SPO 186 core, replacing the fixed bank of per-frequency square-wave sources and the 3-bit tone select. It provides N independent channels, each with:
- a programmable 16-bit half-period,
- square or one-shot mode,
- a 4-bit volume.

Channel outputs are summed into one registered unsigned audio sample. The block sits on the CPU I/O write path next to the LED/relay port latch and feeds the top-level audio output.

## Interface
Parameters:
- CHANNELS, 3: number of tone channels (1..8).
- DIV_W, 16: half-period counter width (≥14).
- PRESCALE, 8: clk_sys cycles per counter tick (≥1); 8 MHz / 8 = 1 MHz tick.
- AW, $clog2(CHANNELS)+2: register address width.

Ports:
- clk_sys  in  1  system clock (8 MHz). One clock only.
- reset_n  in  1  asynchronous, active-low reset.
- wr  in  1  register write strobe, one clk_sys cycle.
- rd  in  1  register read strobe, one clk_sys cycle.
- addr  in  AW  register address; channel = addr[AW-1:2], offset = addr[1:0].
- din  in  8  write data.
- dout  out  8  read data, valid the cycle after rd.
- tone  out  CHANNELS  raw per-channel square outputs (before volume).
- audio  out  4+$clog2(CHANNELS+1)  mixed sample.
- snd  in  3  legacy tone select; present only with ONDRA_LEGACY_SND_EN.

## Operation
Per-channel registers, selected by offset:
- Offset 0, period low byte: write-only staging.
- Offset 1, period high byte: write commits {high, staged low} into the pending period.
- Offset 2, control:
  - bit0 EN
  - bit1 MODE (0 = square, 1 = one-shot)
  - bits7:4 VOL
- Offset 3, status (read-only):
  - bit0 tone level
  - bit1 one-shot busy
  - bits7:2 zero

Prescaler: free-running counter from 0 to PRESCALE-1; `tick` asserts for one cycle at wrap.

Per-channel counter (DIV_W bits), on each tick while EN=1:
- If cnt == 0:
  - cnt ← active period − 1.
  - Active period ← pending period (glitch-free period changes).
  - Square mode: toggle tone.
  - One-shot mode: on the first reload set tone=1; on the second reload clear tone and clear EN.
- Otherwise cnt decrements.

Control and boundary rules:
- Writing control with EN 0→1:
  - active period ← pending, cnt ← 0, tone ← 0.
  - The first tick therefore reloads the counter.
- EN=0: tone forced 0, counter frozen.
- Active period 0: channel silent (tone held 0, cnt held 0) regardless of EN. Period 1 gives the maximum rate (toggle every tick).
- A write to control in the same cycle as a one-shot self-clear of EN: the write wins.

Mixer: audio = Σ (tone[i] ? VOL[i] : 0), registered. Maximum value is 15·CHANNELS, so no overflow is possible.

Reads: dout ← register addressed at rd. dout holds its value otherwise. Reading offsets 0/1 returns the active period bytes.

## Timing
- Reset values:
  - All registers 0, tone 0, audio 0, dout 0.
  - Prescaler 0, counters 0, all channels disabled.
- Writes take effect on the clk_sys edge where wr=1.
- Read latency: 1 cycle.
- Tone change → audio: 1 cycle.
- Square output frequency = clk_sys / (2·PRESCALE·period).
- Reset asserted mid-tone forces all outputs to 0 asynchronously. The first tick after release occurs PRESCALE cycles later.
- wr and rd in the same cycle to the same address: the write commits, and dout returns the pre-write value.

## Configuration
ONDRA_LEGACY_SND_EN:
- Defined:
  - The snd port exists.
  - A nonzero snd overrides channel 0: EN=1, MODE=square, VOL=15, and the period is taken from the legacy table (1 MHz tick): 1302, 825, 605, 366, 331, 310, 285 for codes 1..7, matching the original seven tones.
  - snd=0 returns channel 0 to its register values.
  - A change of snd restarts channel 0 as an EN 0→1 write would.
- Undefined: no snd port; channel 0 is purely register-driven.

## Structure
- Package ondra_snd_pkg:
  - register offset constants
  - control bit positions
  - legacy period table (function indexed by 3-bit code)
  - channel-state typedef (EN, MODE, VOL, pending/active period, cnt, tone, busy)
- Sub-module ondra_tone_channel: one counter/mode engine, instantiated CHANNELS times.
- Top level holds the prescaler, address decode, read mux, mixer and legacy override.

## Test plan
- Reset, then read every status register → 0x00; audio = 0; tone = 0.
- Channel 1: write period 0x0004, control 0x31 (EN, square, VOL 3) → tone1 toggles every 32 clk_sys cycles; audio alternates 0/3 one cycle behind.
- Channel 0: period 10, one-shot, VOL 15 → tone high for exactly 80 clk_sys cycles; then EN reads 0, busy 0, audio 0.
- Period changed from 4 to 8 mid-tone → current half-period completes at 4 ticks; the next half-period is 8 ticks with no runt pulse.
- All three channels at VOL 15, aligned high → audio = 45. Assert reset_n low mid-cycle → audio and tone go 0 immediately.
- With ONDRA_LEGACY_SND_EN, snd=3'b001 → tone0 period 2604 µs (384 Hz). snd=0 → channel 0 silent.
